// File: rtl/keccak_pkg.sv
// ---------------------------------------------------------------------------
// keccak_pkg
// Shared definitions for the SHA3-512 keccak core and its byte packer.
//   KECCAK_WORD_W     : width of the core's `in` word
//   KECCAK_BYTE_W     : width of one message byte
//   KECCAK_RATE_WORDS : words per absorbed block (576-bit rate / 32)
//   packer_state_e    : packer framing states
//   byte_num_t        : type of the core's `byte_num` input
// ---------------------------------------------------------------------------
package keccak_pkg;

    localparam int KECCAK_WORD_W     = 32;
    localparam int KECCAK_BYTE_W     = 8;
    localparam int KECCAK_RATE_WORDS = 18;

    localparam int BYTES_PER_WORD    = KECCAK_WORD_W / KECCAK_BYTE_W;

    // FILL : gathering bytes into words
    // PAD  : last word was full; a zero terminator word must follow
    // FLUSH: final (is_last) word sits in the slot waiting for the core
    // DONE : final word consumed; idle until reset
    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_PAD   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } packer_state_e;

    typedef logic [1:0] byte_num_t;

endpackage

// File: rtl/keccak_word_slot.sv
// ---------------------------------------------------------------------------
// keccak_word_slot
// Single-entry output register facing the keccak core input protocol.
// Contents stay stable until the core takes them (in_ready && !buffer_full).
// A load in the same cycle as a consume refills the slot without a bubble.
//   clk, rst         : clock, asynchronous active-high reset
//   load_en          : write load_* into the slot this cycle
//   load_word/last/bn: word, is_last flag and byte_num to present
//   k_buffer_full    : core backpressure
//   consume          : the core takes the slot contents at this edge
//   k_in/k_in_ready/k_is_last/k_byte_num : registered core inputs
// ---------------------------------------------------------------------------
module keccak_word_slot
    import keccak_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_en,
    input  logic [KECCAK_WORD_W-1:0] load_word,
    input  logic                     load_last,
    input  byte_num_t                load_bn,
    input  logic                     k_buffer_full,
    output logic                     consume,
    output logic [KECCAK_WORD_W-1:0] k_in,
    output logic                     k_in_ready,
    output logic                     k_is_last,
    output logic [1:0]               k_byte_num
);

    logic [KECCAK_WORD_W-1:0] word_q, word_d;
    logic                     ready_q, ready_d;
    logic                     last_q, last_d;
    byte_num_t                bn_q, bn_d;

    assign consume = ready_q && !k_buffer_full;

    always_comb begin
        word_d  = word_q;
        ready_d = ready_q;
        last_d  = last_q;
        bn_d    = bn_q;
        if (load_en) begin
            word_d  = load_word;
            ready_d = 1'b1;
            last_d  = load_last;
            bn_d    = load_bn;
        end else if (consume) begin
            // Data fields are left as-is; only the valid flag drops.
            ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q  <= '0;
            ready_q <= 1'b0;
            last_q  <= 1'b0;
            bn_q    <= '0;
        end else begin
            word_q  <= word_d;
            ready_q <= ready_d;
            last_q  <= last_d;
            bn_q    <= bn_d;
        end
    end

    assign k_in       = word_q;
    assign k_in_ready = ready_q;
    assign k_is_last  = last_q;
    assign k_byte_num = bn_q;

endmodule

// File: rtl/keccak_byte_packer.sv
// ---------------------------------------------------------------------------
// keccak_byte_packer
// Upstream feeder for the SHA3-512 keccak core. Takes a message one byte per
// cycle (valid/ready), packs bytes MSB-first into 32-bit words and generates
// the core's end-of-message framing: a partial last word carries is_last and
// byte_num=1..3; a message ending on a word boundary (or an empty message)
// is terminated by an extra zero word with is_last=1, byte_num=0.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset (also the
//                     per-message restart shared with keccak)
//   s_byte/s_valid/s_last/s_ready : byte stream in
//   msg_empty       : pulse marking a zero-length message
//   k_in/k_in_ready/k_is_last/k_byte_num : keccak input protocol
//   k_buffer_full   : keccak backpressure
//   done            : final word handed over; idle until reset
//   msg_bytes       : bytes accepted since reset, saturating
//                     (only when KECCAK_PACKER_BYTE_CNT_EN is defined)
//
// Optional feature macro: KECCAK_PACKER_BYTE_CNT_EN
// ---------------------------------------------------------------------------
module keccak_byte_packer
    import keccak_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [KECCAK_BYTE_W-1:0] s_byte,
    input  logic                     s_valid,
    input  logic                     s_last,
    output logic                     s_ready,
    input  logic                     msg_empty,
    output logic [KECCAK_WORD_W-1:0] k_in,
    output logic                     k_in_ready,
    output logic                     k_is_last,
    output logic [1:0]               k_byte_num,
    input  logic                     k_buffer_full,
    output logic                     done
`ifdef KECCAK_PACKER_BYTE_CNT_EN
    ,
    output logic [CNT_W-1:0]         msg_bytes
`endif
);

    if (CNT_W < 1) begin : g_cnt_w_chk
        $error("CNT_W must be at least 1");
    end

    packer_state_e state_q, state_d;

    logic [BYTES_PER_WORD-1:0][KECCAK_BYTE_W-1:0] acc_q, acc_d;
    logic [BYTES_PER_WORD-1:0][KECCAK_BYTE_W-1:0] word_with_byte;
    logic [1:0]                                   acc_cnt_q, acc_cnt_d;
    logic                                         seen_byte_q, seen_byte_d;

    logic                     consume;
    logic                     byte_fire;
    logic                     word_full;
    logic                     empty_ok;
    logic                     load_en;
    logic [KECCAK_WORD_W-1:0] load_word;
    logic                     load_last;
    byte_num_t                load_bn;

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    // Byte i of a word lands in bits [31-8i -: 8]; with packed [3:0][7:0]
    // that is element 3-i. Bytes not yet written are still zero, which
    // gives the zero-filled tail of a partial last word for free.
    always_comb begin
        word_with_byte                   = acc_q;
        word_with_byte[2'd3 - acc_cnt_q] = s_byte;
    end

    assign word_full = (acc_cnt_q == 2'd3);
    assign byte_fire = s_valid && s_ready;

    // An empty-message marker is only meaningful before any byte of this
    // message; a byte accepted in the same cycle takes precedence.
    assign empty_ok  = msg_empty && (acc_cnt_q == 2'd0) && !seen_byte_q && !byte_fire;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_FILL;
        else     state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FILL: begin
                if (byte_fire && s_last) state_d = word_full ? ST_PAD : ST_FLUSH;
                else if (empty_ok)       state_d = ST_FLUSH;
            end
            ST_PAD:   if (consume) state_d = ST_FLUSH;
            ST_FLUSH: if (consume) state_d = ST_DONE;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_FILL;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (stream handshake and slot load requests)
    // ------------------------------------------------------------------
    always_comb begin
        // s_ready looks at k_buffer_full through consume so a word can be
        // handed off and its successor started in the same cycle.
        s_ready   = !rst && (state_q == ST_FILL) && (!k_in_ready || consume);
        done      = (state_q == ST_DONE);
        load_en   = 1'b0;
        load_word = '0;
        load_last = 1'b0;
        load_bn   = '0;
        unique case (state_q)
            ST_FILL: begin
                if (byte_fire && (word_full || s_last)) begin
                    load_en   = 1'b1;
                    load_word = word_with_byte;
                    // A final byte that fills the word is not is_last: the
                    // zero terminator word follows from PAD.
                    load_last = s_last && !word_full;
                    load_bn   = (s_last && !word_full) ? acc_cnt_q + 2'd1 : 2'd0;
                end else if (empty_ok) begin
                    load_en   = 1'b1;
                    load_last = 1'b1;
                end
            end
            ST_PAD: begin
                if (consume) begin
                    load_en   = 1'b1;
                    load_last = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Byte accumulator
    // ------------------------------------------------------------------
    always_comb begin
        acc_d       = acc_q;
        acc_cnt_d   = acc_cnt_q;
        seen_byte_d = seen_byte_q || byte_fire;
        if (byte_fire) begin
            if (word_full || s_last) begin
                acc_d     = '0;
                acc_cnt_d = 2'd0;
            end else begin
                acc_d     = word_with_byte;
                acc_cnt_d = acc_cnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            acc_cnt_q   <= 2'd0;
            seen_byte_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            acc_cnt_q   <= acc_cnt_d;
            seen_byte_q <= seen_byte_d;
        end
    end

    // ------------------------------------------------------------------
    // Output slot
    // ------------------------------------------------------------------
    keccak_word_slot u_slot (
        .clk           (clk),
        .rst           (rst),
        .load_en       (load_en),
        .load_word     (load_word),
        .load_last     (load_last),
        .load_bn       (load_bn),
        .k_buffer_full (k_buffer_full),
        .consume       (consume),
        .k_in          (k_in),
        .k_in_ready    (k_in_ready),
        .k_is_last     (k_is_last),
        .k_byte_num    (k_byte_num)
    );

`ifdef KECCAK_PACKER_BYTE_CNT_EN
    // ------------------------------------------------------------------
    // Accepted-byte counter; no bytes are accepted in DONE, so it freezes
    // there without extra logic.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] msg_bytes_q, msg_bytes_d;

    always_comb begin
        msg_bytes_d = msg_bytes_q;
        if (byte_fire && (msg_bytes_q != {CNT_W{1'b1}})) msg_bytes_d = msg_bytes_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) msg_bytes_q <= '0;
        else     msg_bytes_q <= msg_bytes_d;
    end

    assign msg_bytes = msg_bytes_q;
`endif

endmodule

// File: tb/tb_keccak_byte_packer.sv
// ---------------------------------------------------------------------------
// tb_keccak_byte_packer
// Directed bench for keccak_byte_packer. Expected keccak words are derived
// from the message bytes by a chunking model; a monitor compares every word
// the core would take, checks stall stability and s_ready during stalls.
// ---------------------------------------------------------------------------
module tb_keccak_byte_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_byte = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic        msg_empty = 1'b0;
    logic [31:0] k_in;
    logic        k_in_ready;
    logic        k_is_last;
    logic [1:0]  k_byte_num;
    logic        k_buffer_full = 1'b0;
    logic        done;
`ifdef KECCAK_PACKER_BYTE_CNT_EN
    logic [31:0] msg_bytes;
`endif

    keccak_byte_packer #(.CNT_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_byte        (s_byte),
        .s_valid       (s_valid),
        .s_last        (s_last),
        .s_ready       (s_ready),
        .msg_empty     (msg_empty),
        .k_in          (k_in),
        .k_in_ready    (k_in_ready),
        .k_is_last     (k_is_last),
        .k_byte_num    (k_byte_num),
        .k_buffer_full (k_buffer_full),
        .done          (done)
`ifdef KECCAK_PACKER_BYTE_CNT_EN
        ,
        .msg_bytes     (msg_bytes)
`endif
    );

    always #5 clk = ~clk;

    int          vec  = 0;
    int          errs = 0;
    logic [7:0]  msg [0:127];
    logic [31:0] exp_w [$];
    bit          exp_l [$];
    logic [1:0]  exp_b [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        vec++;
        if (act !== want) begin
            errs++;
            $display("FAIL %s: got %08h want %08h at %0t", name, act, want, $time);
        end
    endtask

    // Model: split n message bytes into words, MSB-first. With framing, a
    // partial tail is is_last with byte_num = tail length; an exact multiple
    // of 4 (including 0) gets a trailing zero word with byte_num 0.
    task automatic model_msg(input int n, input bit framed);
        int full = n / 4;
        int rem  = n % 4;
        logic [31:0] w;
        for (int i = 0; i < full; i++) begin
            w = {msg[4*i], msg[4*i+1], msg[4*i+2], msg[4*i+3]};
            exp_w.push_back(w); exp_l.push_back(1'b0); exp_b.push_back(2'd0);
        end
        if (framed) begin
            w = '0;
            for (int j = 0; j < rem; j++) w[31-8*j -: 8] = msg[4*full+j];
            exp_w.push_back(w); exp_l.push_back(1'b1); exp_b.push_back(2'(rem));
        end
    endtask

    task automatic clear_model();
        exp_w.delete(); exp_l.delete(); exp_b.delete();
    endtask

    // Checks run at negedge+2: inputs for the coming posedge are settled.
    task automatic monitor();
        bit          stall_prev = 1'b0;
        logic [31:0] sw;
        logic        sl;
        logic [1:0]  sb;
        forever begin
            @(negedge clk); #2;
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    chk("stall_ready", {31'd0, k_in_ready}, 32'd1);
                    chk("stall_k_in", k_in, sw);
                    chk("stall_meta", {29'd0, k_is_last, k_byte_num}, {29'd0, sl, sb});
                end
                stall_prev = 1'b0;
                if (k_in_ready && k_buffer_full) begin
                    chk("stall_s_ready", {31'd0, s_ready}, 32'd0);
                    stall_prev = 1'b1;
                    sw = k_in; sl = k_is_last; sb = k_byte_num;
                end
                if (k_in_ready && !k_buffer_full) begin
                    if (exp_w.size() == 0) begin
                        vec++; errs++;
                        $display("FAIL unexpected_word: got %08h want none at %0t", k_in, $time);
                    end else begin
                        chk("word", k_in, exp_w.pop_front());
                        chk("is_last", {31'd0, k_is_last}, {31'd0, exp_l.pop_front()});
                        chk("byte_num", {30'd0, k_byte_num}, {30'd0, exp_b.pop_front()});
                    end
                end
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; msg_empty = 1'b0; k_buffer_full = 1'b0;
        clear_model();
        #1;
        chk("rst_k_in", k_in, 32'd0);
        chk("rst_k_in_ready", {31'd0, k_in_ready}, 32'd0);
        chk("rst_k_is_last", {31'd0, k_is_last}, 32'd0);
        chk("rst_k_byte_num", {30'd0, k_byte_num}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Present n bytes of msg[], holding each until accepted.
    task automatic send_msg(input int n, input bit with_last);
        for (int i = 0; i < n; i++) begin
            int tmo = 0;
            @(negedge clk);
            s_byte = msg[i]; s_valid = 1'b1; s_last = with_last && (i == n - 1);
            #1;
            while (!s_ready && tmo < 200) begin
                @(negedge clk); #1; tmo++;
            end
            if (!s_ready) begin
                vec++; errs++;
                $display("FAIL send_timeout: byte %0d never accepted", i);
                break;
            end
        end
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 200) begin
            @(negedge clk); #3; t++;
        end
        chk("done", {31'd0, done}, 32'd1);
        chk("all_words_seen", exp_w.size(), 32'd0);
        repeat (3) begin
            @(negedge clk); #3;
            chk("done_hold", {30'd0, done, k_in_ready}, 32'd2);
        end
    endtask

    task automatic load_a();
        msg[0] = 8'hA1; msg[1] = 8'hA2; msg[2] = 8'hA3; msg[3] = 8'hA4;
    endtask

    initial begin
        string fox;
        fork monitor(); join_none

        // --- scenario 1: A1..A4, word-aligned -> zero terminator word
        apply_reset();
        load_a();
        model_msg(4, 1'b1);
        chk("model_a_w0", exp_w[0], 32'hA1A2A3A4);
        chk("model_a_w1", {exp_w[1][29:0], exp_l[1], 1'b0} | {30'd0, exp_b[1]}, 32'h2);
        send_msg(4, 1'b1);
        wait_done();
`ifdef KECCAK_PACKER_BYTE_CNT_EN
        chk("msg_bytes_a", msg_bytes, 32'd4);
`endif

        // --- scenario 2: B1..B5, partial last word
        apply_reset();
        for (int i = 0; i < 5; i++) msg[i] = 8'hB1 + 8'(i);
        model_msg(5, 1'b1);
        chk("model_b_w1", exp_w[1], 32'hB5000000);
        chk("model_b_bn1", {30'd0, exp_b[1]}, 32'd1);
        send_msg(5, 1'b1);
        wait_done();

        // --- scenario 3: empty message, then bytes refused
        apply_reset();
        model_msg(0, 1'b1);
        @(negedge clk); msg_empty = 1'b1;
        @(negedge clk); msg_empty = 1'b0;
        wait_done();
        msg[0] = 8'h12; msg[1] = 8'h34; msg[2] = 8'h56; msg[3] = 8'h78;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s_byte = msg[i]; s_valid = 1'b1; s_last = (i == 3); msg_empty = 1'b1;
            #1;
            chk("done_s_ready", {31'd0, s_ready}, 32'd0);
        end
        @(negedge clk); s_valid = 1'b0; s_last = 1'b0; msg_empty = 1'b0;
        repeat (3) @(negedge clk);

        // --- scenario 4: 72 bytes with a 5-cycle stall mid-stream
        apply_reset();
        for (int i = 0; i < 72; i++) begin
            logic [63:0] pat;
            pat = 64'h1234567890abcdef;
            msg[i] = pat[63-8*(i%8) -: 8];
        end
        model_msg(72, 1'b1);
        chk("model_s_w1", exp_w[1], 32'h90abcdef);
        fork
            send_msg(72, 1'b1);
            begin
                repeat (30) @(negedge clk);
                k_buffer_full = 1'b1;
                repeat (5) @(negedge clk);
                k_buffer_full = 1'b0;
            end
        join
        wait_done();

        // --- scenario 5: 44-byte pangram
        apply_reset();
        fox = "The quick brown fox jumps over the lazy dog.";
        for (int i = 0; i < fox.len(); i++) msg[i] = fox[i];
        model_msg(fox.len(), 1'b1);
        chk("model_fox_w0", exp_w[0], 32'h54686520);
        chk("model_fox_n", exp_w.size(), 32'd12);
        send_msg(fox.len(), 1'b1);
        wait_done();

        // --- scenario 6: abort after 6 bytes, then scenario 1 again
        apply_reset();
        for (int i = 0; i < 6; i++) msg[i] = 8'hC1 + 8'(i);
        model_msg(6, 1'b0);
        send_msg(6, 1'b0);
        apply_reset();
        load_a();
        model_msg(4, 1'b1);
        send_msg(4, 1'b1);
        wait_done();

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
